// File: rtl/vending_pkg.sv
// Shared vending definitions: coin denominations, coin-index codes and dispenser states.
package vending_pkg;

    localparam int NUM_DENOM = 6;

    localparam logic [2:0] COIN_500 = 3'd0;
    localparam logic [2:0] COIN_100 = 3'd1;
    localparam logic [2:0] COIN_25  = 3'd2;
    localparam logic [2:0] COIN_10  = 3'd3;
    localparam logic [2:0] COIN_5   = 3'd4;
    localparam logic [2:0] COIN_1   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_SELECT = 3'b001,
        S_EJECT  = 3'b010,
        S_DONE   = 3'b011
    } disp_state_e;

    // Value in cents of a coin index; out-of-range indices are worth nothing.
    function automatic logic [15:0] denom_of(input logic [2:0] idx);
        case (idx)
            COIN_500: denom_of = 16'd500;
            COIN_100: denom_of = 16'd100;
            COIN_25:  denom_of = 16'd25;
            COIN_10:  denom_of = 16'd10;
            COIN_5:   denom_of = 16'd5;
            COIN_1:   denom_of = 16'd1;
            default:  denom_of = 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_inventory.sv
// Six saturating per-denomination coin counters with decrement, refill and empty flags.
module coin_inventory
    import vending_pkg::*;
#(
    parameter int INV_W    = 8,
    parameter int INV_INIT = 20
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_dec,
    input  logic [2:0]       i_dec_idx,
    input  logic             i_refill,
    input  logic [2:0]       i_refill_sel,
    input  logic [INV_W-1:0] i_refill_cnt,
    output logic [5:0]       o_empty
);

    logic [INV_W-1:0] r_inv [NUM_DENOM];
    logic [INV_W:0]   w_sum [NUM_DENOM];

    // One extra bit of headroom so refill overflow is visible for saturation.
    always_comb begin
        for (int i = 0; i < NUM_DENOM; i++) begin
            w_sum[i] = {1'b0, r_inv[i]}
                     + ((i_refill && i_refill_sel == 3'(i)) ? {1'b0, i_refill_cnt} : '0)
                     - ((i_dec && i_dec_idx == 3'(i) && r_inv[i] != '0) ? (INV_W+1)'(1) : '0);
            o_empty[i] = (r_inv[i] == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (i_reset) begin
                r_inv[i] <= INV_W'(INV_INIT);
            end else if (w_sum[i][INV_W]) begin
                r_inv[i] <= '1;
            end else begin
                r_inv[i] <= w_sum[i][INV_W-1:0];
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays an amount one coin per ejector handshake, largest coin first.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int INV_W    = 8,
    parameter int INV_INIT = 20
) (
    input  logic             I_CLK,
    input  logic             I_RESET,
    input  logic             I_START,
    input  logic [15:0]      I_AMOUNT,
    input  logic             I_COIN_ACK,
    input  logic             I_REFILL,
    input  logic [2:0]       I_REFILL_SEL,
    input  logic [INV_W-1:0] I_REFILL_CNT,
    output logic             O_BUSY,
    output logic             O_COIN_VALID,
    output logic [2:0]       O_COIN_SEL,
    output logic [15:0]      O_REMAIN,
    output logic             O_DONE,
    output logic             O_SHORT,
    output logic [5:0]       O_EMPTY
);

    disp_state_e r_state, w_state_d;
    logic [15:0] r_remain, w_remain_d;
    logic [2:0]  r_idx, w_idx_d;
    logic [2:0]  r_coin_sel, w_coin_sel_d;
    logic        w_dec;
    logic [5:0]  w_empty;
    logic        w_can_pay;

    coin_inventory #(
        .INV_W    (INV_W),
        .INV_INIT (INV_INIT)
    ) u_inv (
        .i_clk        (I_CLK),
        .i_reset      (I_RESET),
        .i_dec        (w_dec),
        .i_dec_idx    (r_idx),
        .i_refill     (I_REFILL),
        .i_refill_sel (I_REFILL_SEL),
        .i_refill_cnt (I_REFILL_CNT),
        .o_empty      (w_empty)
    );

    assign w_can_pay = (denom_of(r_idx) <= r_remain) && !w_empty[r_idx];

    always_comb begin
        w_state_d    = r_state;
        w_remain_d   = r_remain;
        w_idx_d      = r_idx;
        w_coin_sel_d = r_coin_sel;
        w_dec        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (I_START) begin
                    w_remain_d = I_AMOUNT;
                    w_idx_d    = 3'd0;
                    w_state_d  = S_SELECT;
                end
            end
            S_SELECT: begin
                if (r_remain == 16'd0 || r_idx == 3'(NUM_DENOM)) begin
                    w_state_d = S_DONE;
                end else if (w_can_pay) begin
                    w_coin_sel_d = r_idx;
                    w_state_d    = S_EJECT;
                end else begin
                    w_idx_d = r_idx + 3'd1;
                end
            end
            S_EJECT: begin
                // idx stays put so the same denomination is tried again.
                if (I_COIN_ACK) begin
                    w_remain_d = r_remain - denom_of(r_idx);
                    w_dec      = 1'b1;
                    w_state_d  = S_SELECT;
                end
            end
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_state    <= S_IDLE;
            r_remain   <= 16'd0;
            r_idx      <= 3'd0;
            r_coin_sel <= 3'd0;
        end else begin
            r_state    <= w_state_d;
            r_remain   <= w_remain_d;
            r_idx      <= w_idx_d;
            r_coin_sel <= w_coin_sel_d;
        end
    end

    always_comb begin
        O_BUSY       = (r_state != S_IDLE);
        O_COIN_VALID = (r_state == S_EJECT);
        O_COIN_SEL   = r_coin_sel;
        O_REMAIN     = r_remain;
        O_DONE       = (r_state == S_DONE);
        O_SHORT      = (r_state == S_DONE) && (r_remain != 16'd0);
        O_EMPTY      = w_empty;
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a full-stock (INV_INIT=20) and a one-coin (INV_INIT=1) DUT.
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        rst, start, ack, refill;
    logic [15:0] amount;
    logic [2:0]  refill_sel;
    logic [7:0]  refill_cnt;
    logic        sel_b;

    logic        a_busy, a_valid, a_done, a_short, b_busy, b_valid, b_done, b_short;
    logic [2:0]  a_sel, b_sel;
    logic [15:0] a_remain, b_remain;
    logic [5:0]  a_empty, b_empty;

    logic        busy, valid, done, short_f;
    logic [2:0]  csel;
    logic [15:0] remain;
    logic [5:0]  empty;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    change_dispenser #(.INV_W(8), .INV_INIT(20)) dut_a (
        .I_CLK(clk), .I_RESET(rst), .I_START(start), .I_AMOUNT(amount), .I_COIN_ACK(ack),
        .I_REFILL(refill), .I_REFILL_SEL(refill_sel), .I_REFILL_CNT(refill_cnt),
        .O_BUSY(a_busy), .O_COIN_VALID(a_valid), .O_COIN_SEL(a_sel), .O_REMAIN(a_remain),
        .O_DONE(a_done), .O_SHORT(a_short), .O_EMPTY(a_empty)
    );

    change_dispenser #(.INV_W(8), .INV_INIT(1)) dut_b (
        .I_CLK(clk), .I_RESET(rst), .I_START(start), .I_AMOUNT(amount), .I_COIN_ACK(ack),
        .I_REFILL(refill), .I_REFILL_SEL(refill_sel), .I_REFILL_CNT(refill_cnt),
        .O_BUSY(b_busy), .O_COIN_VALID(b_valid), .O_COIN_SEL(b_sel), .O_REMAIN(b_remain),
        .O_DONE(b_done), .O_SHORT(b_short), .O_EMPTY(b_empty)
    );

    always_comb begin
        busy    = sel_b ? b_busy   : a_busy;
        valid   = sel_b ? b_valid  : a_valid;
        done    = sel_b ? b_done   : a_done;
        short_f = sel_b ? b_short  : a_short;
        csel    = sel_b ? b_sel    : a_sel;
        remain  = sel_b ? b_remain : a_remain;
        empty   = sel_b ? b_empty  : a_empty;
    end

    typedef struct {
        logic        use_b;
        logic [15:0] amount;
        string       coins;
        logic        exp_short;
        logic [15:0] exp_remain;
        logic [5:0]  exp_empty;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; ack = 1'b0; refill = 1'b0;
        amount = 16'd0; refill_sel = 3'd0; refill_cnt = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int  k = 0;
        bit  got_done = 1'b0;
        sel_b = v.use_b;
        do_reset();
        start = 1'b1; amount = v.amount;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            ack = 1'b0;
            if (valid) begin
                if (k < v.coins.len())
                    check($sformatf("v%0d coin%0d sel", n, k), int'(csel),
                          int'(v.coins[k]) - 48);
                k++;
                ack = 1'b1;
            end
            if (done) begin
                got_done = 1'b1;
                check($sformatf("v%0d short", n), int'(short_f), int'(v.exp_short));
                check($sformatf("v%0d remain", n), int'(remain), int'(v.exp_remain));
                check($sformatf("v%0d empty", n), int'(empty), int'(v.exp_empty));
            end
            if (!got_done) @(negedge clk);
        end
        check($sformatf("v%0d done seen", n), int'(got_done), 1);
        check($sformatf("v%0d coin count", n), k, v.coins.len());
        @(negedge clk);
        check($sformatf("v%0d idle after done", n), int'(busy), 0);
        check($sformatf("v%0d remain held", n), int'(remain), int'(v.exp_remain));
    endtask

    task automatic wait_valid(input string name);
        int cyc = 0;
        while (!valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check(name, int'(valid), 1);
    endtask

    initial begin
        vecs[0] = '{use_b: 1'b0, amount: 16'd150,  coins: "122",        exp_short: 1'b0,
                    exp_remain: 16'd0,   exp_empty: 6'b000000};
        vecs[1] = '{use_b: 1'b0, amount: 16'd37,   coins: "2355",       exp_short: 1'b0,
                    exp_remain: 16'd0,   exp_empty: 6'b000000};
        vecs[2] = '{use_b: 1'b0, amount: 16'd1234, coins: "0011245555", exp_short: 1'b0,
                    exp_remain: 16'd0,   exp_empty: 6'b000000};
        vecs[3] = '{use_b: 1'b1, amount: 16'd50,   coins: "2345",       exp_short: 1'b1,
                    exp_remain: 16'd9,   exp_empty: 6'b111100};
        vecs[4] = '{use_b: 1'b1, amount: 16'd1200, coins: "012345",     exp_short: 1'b1,
                    exp_remain: 16'd559, exp_empty: 6'b111111};
        vecs[5] = '{use_b: 1'b1, amount: 16'd600,  coins: "01",         exp_short: 1'b0,
                    exp_remain: 16'd0,   exp_empty: 6'b000011};

        // Reset state
        sel_b = 1'b0;
        do_reset();
        check("reset busy", int'(busy), 0);
        check("reset remain", int'(remain), 0);
        check("reset valid", int'(valid), 0);
        check("reset sel", int'(csel), 0);
        check("reset empty", int'(empty), 0);

        // Reset while a coin is presented
        @(negedge clk);
        start = 1'b1; amount = 16'd100;
        @(negedge clk);
        start = 1'b0;
        wait_valid("midreset valid reached");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset valid drop", int'(valid), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset remain", int'(remain), 0);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Zero amount: done two cycles after start, start while busy ignored
        sel_b = 1'b0;
        do_reset();
        start = 1'b1; amount = 16'd0;
        @(negedge clk);
        check("zero select busy", int'(busy), 1);
        check("zero select done", int'(done), 0);
        start = 1'b1; amount = 16'd500;
        @(negedge clk);
        start = 1'b0;
        check("zero done at N+2", int'(done), 1);
        check("zero short", int'(short_f), 0);
        check("zero valid", int'(valid), 0);
        @(negedge clk);
        check("zero idle", int'(busy), 0);
        check("zero remain", int'(remain), 0);

        // Ack stall, start-while-busy, refill coinciding with ack on the same denomination
        do_reset();
        start = 1'b1; amount = 16'd100;
        @(negedge clk);
        start = 1'b0;
        wait_valid("stall valid reached");
        for (int c = 0; c < 5; c++) begin
            start = 1'b1; amount = 16'd7;
            check($sformatf("stall%0d valid", c), int'(valid), 1);
            check($sformatf("stall%0d sel", c), int'(csel), 1);
            @(negedge clk);
        end
        start = 1'b0;
        ack = 1'b1; refill = 1'b1; refill_sel = 3'd1; refill_cnt = 8'd3;
        @(negedge clk);
        ack = 1'b0; refill = 1'b0;
        check("refill+ack inv1", int'(dut_a.u_inv.r_inv[1]), 22);
        check("post ack valid", int'(valid), 0);
        @(negedge clk);
        check("stall done", int'(done), 1);
        check("stall short", int'(short_f), 0);
        check("stall remain", int'(remain), 0);

        // Saturation and ignored refill index
        do_reset();
        refill = 1'b1; refill_sel = 3'd5; refill_cnt = 8'd250;
        @(negedge clk);
        refill_sel = 3'd6; refill_cnt = 8'd5;
        @(negedge clk);
        refill = 1'b0;
        check("refill saturate", int'(dut_a.u_inv.r_inv[5]), 255);
        check("refill idx6 ignored", int'(dut_a.u_inv.r_inv[0]), 20);
        check("refill empty", int'(empty), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
